// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory loader.
// Holds the loader state encoding, default memory depth and header count width.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam int IMEM_DEPTH = 1000;
  localparam int HDR_CNT_W  = 16;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four bytes little-endian into one 32-bit word.
// Ports: clk_i, rst_ni (sync, active-low), clr_i, push_i, byte_i -> word_o, cnt_o, word_ready_o.
module byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        push_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [2:0]  cnt_o,
  output logic        word_ready_o
);

  logic [31:0] word_q, word_d;
  logic [2:0]  cnt_q, cnt_d;

  // New bytes enter at the top and shift down, so the
  // first byte ends up in bits [7:0] after four pushes.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (push_i && cnt_q != 3'd4) begin
      word_d = {byte_i, word_q[31:8]};
      cnt_d  = cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o       = word_q;
  assign cnt_o        = cnt_q;
  assign word_ready_o = (cnt_q == 3'd4);

endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a length-prefixed byte image into instruction memory.
// Ports: SYS_clk, SYS_reset, start, in_valid/in_data/in_ready, mem_we/addr/wdata, cpu_hold, done, err.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = IMEM_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic              SYS_clk,
  input  logic              SYS_reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_e                 state_q, state_d;
  logic [HDR_CNT_W-1:0]   cnt_q, cnt_d;
  logic [HDR_CNT_W-1:0]   idx_q, idx_d;
  logic [HDR_CNT_W-1:0]   hdr_cnt;
  logic                   err_q, err_d;
  logic                   pk_clr;
  logic                   pk_push;
  logic [31:0]            pk_word;
  logic [2:0]             pk_cnt;
  logic                   pk_rdy;
  logic                   in_range;

  byte_packer u_packer (
    .clk_i        (SYS_clk),
    .rst_ni       (SYS_reset),
    .clr_i        (pk_clr),
    .push_i       (pk_push),
    .byte_i       (in_data),
    .word_o       (pk_word),
    .cnt_o        (pk_cnt),
    .word_ready_o (pk_rdy)
  );

  assign hdr_cnt  = {in_data, cnt_q[7:0]};
  assign in_range = 32'(idx_q) < 32'(DEPTH);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    err_d     = err_q;
    pk_clr    = 1'b0;
    pk_push   = 1'b0;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_hold  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          state_d = ST_HDR0;
          cnt_d   = '0;
          idx_d   = '0;
          err_d   = 1'b0;
          pk_clr  = 1'b1;
        end
      end
      ST_HDR0: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) begin
          cnt_d   = {cnt_q[HDR_CNT_W-1:8], in_data};
          state_d = ST_HDR1;
        end
      end
      ST_HDR1: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) begin
          cnt_d   = hdr_cnt;
          // Oversized images keep streaming so the source drains.
          err_d   = 32'(hdr_cnt) > 32'(DEPTH);
          state_d = (hdr_cnt == '0) ? ST_DONE : ST_DATA;
        end
      end
      ST_DATA: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        pk_push  = in_valid;
        // 4th byte: go straight to WRITE for next-cycle strobe.
        if (in_valid && pk_cnt == 3'd3) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        cpu_hold  = 1'b1;
        mem_we    = pk_rdy && in_range;
        mem_addr  = ADDR_W'({idx_q, 2'b00});
        mem_wdata = pk_word;
        pk_clr    = 1'b1;
        idx_d     = idx_q + 1'b1;
        state_d   = (idx_d == cnt_q) ? ST_DONE : ST_DATA;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge SYS_clk) begin
    if (!SYS_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader.
// Drives two instances (default depth and depth 2) with one shared stream.
module tb_imem_loader;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        in_ready_a, mem_we_a, cpu_hold_a, done_a, err_a;
  logic [31:0] mem_addr_a, mem_wdata_a;
  logic        in_ready_b, mem_we_b, cpu_hold_b, done_b, err_b;
  logic [31:0] mem_addr_b, mem_wdata_b;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs = -1;

  logic [63:0] got_a[$];
  logic [63:0] got_b[$];
  logic [7:0]  stim[$];

  always #5 SYS_clk = ~SYS_clk;

  always @(posedge SYS_clk) cyc <= cyc + 1;

  imem_loader dut_a (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_a),
    .mem_we    (mem_we_a),
    .mem_addr  (mem_addr_a),
    .mem_wdata (mem_wdata_a),
    .cpu_hold  (cpu_hold_a),
    .done      (done_a),
    .err       (err_a)
  );

  imem_loader #(.DEPTH(2)) dut_b (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready_b),
    .mem_we    (mem_we_b),
    .mem_addr  (mem_addr_b),
    .mem_wdata (mem_wdata_b),
    .cpu_hold  (cpu_hold_b),
    .done      (done_b),
    .err       (err_b)
  );

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Log every write; the strobe must follow the last handshake.
  always @(negedge SYS_clk) begin
    if (mem_we_a) begin
      got_a.push_back({mem_addr_a, mem_wdata_a});
      chk("lat_a", 64'(cyc), 64'(last_hs));
    end
    if (mem_we_b) begin
      got_b.push_back({mem_addr_b, mem_wdata_b});
      chk("lat_b", 64'(cyc), 64'(last_hs));
    end
  end

  task automatic idle_chk(string tag);
    chk({tag, "_ctl"},
        {in_ready_a, mem_we_a, cpu_hold_a, done_a, err_a,
         in_ready_b, mem_we_b, cpu_hold_b, done_b, err_b}, 0);
    chk({tag, "_bus_a"}, {mem_addr_a, mem_wdata_a}, 0);
    chk({tag, "_bus_b"}, {mem_addr_b, mem_wdata_b}, 0);
  endtask

  task automatic two_word();
    stim = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
             8'h93, 8'h00, 8'h10, 8'h00};
  endtask

  task automatic build_rand(int n);
    stim.delete();
    stim.push_back(8'(n));
    stim.push_back(8'(n >> 8));
    repeat (4 * n) stim.push_back(8'($urandom));
  endtask

  // mode: 0 valid always, 1 valid toggling, 2 valid random.
  task automatic run_load(int mode, bit do_start, bit mid_start,
                          int stop_at);
    int n;
    int ptr;
    int guard;
    bit hs;
    bit tog;
    logic [31:0] word;
    logic [63:0] exp_a[$];
    logic [63:0] exp_b[$];
    ptr = 0;
    guard = 0;
    tog = 1'b0;
    n = int'({stim[1], stim[0]});
    for (int w = 0; w < n; w++) begin
      word = {stim[2+4*w+3], stim[2+4*w+2],
              stim[2+4*w+1], stim[2+4*w]};
      if (w < 1000) exp_a.push_back({32'(w * 4), word});
      if (w < 2) exp_b.push_back({32'(w * 4), word});
    end
    got_a.delete();
    got_b.delete();
    if (do_start) begin
      @(negedge SYS_clk);
      start = 1'b1;
      @(negedge SYS_clk);
      start = 1'b0;
    end
    while (ptr < stim.size() && guard < 3000) begin
      @(negedge SYS_clk);
      start = mid_start && ptr == 4;
      tog = ~tog;
      case (mode)
        0: in_valid = 1'b1;
        1: in_valid = tog;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = stim[ptr];
      hs = in_valid && in_ready_a;
      @(posedge SYS_clk);
      #1;
      if (hs) begin
        last_hs = cyc;
        ptr++;
        if (ptr == 2) begin
          in_valid = 1'b0;
          start = 1'b0;
          @(negedge SYS_clk);
          chk("err_hdr_a", err_a, n > 1000);
          chk("err_hdr_b", err_b, n > 2);
          chk("hold_hdr", cpu_hold_a, n != 0);
        end
      end
      guard++;
      if (stop_at > 0 && ptr == stop_at) break;
    end
    in_valid = 1'b0;
    start = 1'b0;
    if (stop_at > 0) return;
    chk("feed_bytes", 64'(ptr), 64'(stim.size()));
    guard = 0;
    while (!done_a && guard < 20) begin
      @(negedge SYS_clk);
      guard++;
    end
    @(negedge SYS_clk);
    chk("done_a", done_a, 1);
    chk("done_b", done_b, 1);
    chk("hold_end", {cpu_hold_a, cpu_hold_b}, 0);
    chk("rdy_end", {in_ready_a, in_ready_b}, 0);
    chk("err_a", err_a, n > 1000);
    chk("err_b", err_b, n > 2);
    chk("nwr_a", 64'(got_a.size()), 64'(exp_a.size()));
    chk("nwr_b", 64'(got_b.size()), 64'(exp_b.size()));
    for (int i = 0; i < exp_a.size() && i < got_a.size(); i++)
      chk("wr_a", got_a[i], exp_a[i]);
    for (int i = 0; i < exp_b.size() && i < got_b.size(); i++)
      chk("wr_b", got_b[i], exp_b[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge SYS_clk);
    idle_chk("rst");
    SYS_reset = 1'b1;

    two_word();
    run_load(0, 1'b1, 1'b0, 0);

    stim = '{8'h00, 8'h00};
    run_load(0, 1'b1, 1'b0, 0);

    two_word();
    run_load(1, 1'b1, 1'b0, 0);

    build_rand(3);
    run_load(2, 1'b1, 1'b1, 0);

    @(negedge SYS_clk);
    start = 1'b1;
    @(negedge SYS_clk);
    start = 1'b0;
    chk("rs_done", {done_a, done_b}, 0);
    chk("rs_err", {err_a, err_b}, 0);
    chk("rs_hold", cpu_hold_a, 1);
    chk("rs_rdy", in_ready_a, 1);
    two_word();
    run_load(0, 1'b0, 1'b0, 0);

    two_word();
    run_load(0, 1'b1, 1'b0, 4);
    @(negedge SYS_clk);
    SYS_reset = 1'b0;
    @(negedge SYS_clk);
    idle_chk("mid_rst");
    chk("mid_rst_wr", 64'(got_a.size() + got_b.size()), 0);
    SYS_reset = 1'b1;
    run_load(0, 1'b1, 1'b0, 0);

    for (int k = 0; k < 10; k++) begin
      build_rand($urandom_range(0, 5));
      run_load($urandom_range(0, 2), 1'b1,
               1'($urandom_range(0, 1)), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter DEPTH, default 1000, means the instruction-memory depth in 32-bit words.
REQ-002 Parameter ADDR_W, default 32, means the width of the mem_addr byte address.
REQ-003 SYS_clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 SYS_reset  input  1  reset, synchronous and active-low (0 = reset).
REQ-005 start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-006 in_valid  input  1  a byte is presented on in_data.
REQ-007 in_data  input  8  serial program byte stream.
REQ-008 in_ready  output  1  loader accepts a byte; a transfer occurs when in_valid and in_ready are both 1.
REQ-009 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-010 mem_addr  output  ADDR_W  byte address of the write, word-aligned (word index times 4).
REQ-011 mem_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the core's fetch/PC while a load is in progress.
REQ-013 done  output  1  load finished; level, held until the next start.
REQ-014 err  output  1  header word count exceeded DEPTH; level, held until the next start.

Function
REQ-015 States: IDLE, HDR0, HDR1, DATA, WRITE, DONE.
REQ-016 IDLE or DONE, with start=1 -> HDR0; clears done, err, the word counter and the byte counter in the same transition.
REQ-017 start in HDR0, HDR1, DATA or WRITE is ignored.
REQ-018 in_ready = 1 in HDR0, HDR1 and DATA only; 0 in IDLE, WRITE and DONE.
REQ-019 HDR0: an accepted byte becomes count[7:0] -> HDR1. HDR1: an accepted byte becomes count[15:8] -> DATA, or -> DONE if count=0.
REQ-020 If count > DEPTH in HDR1, err is set at the HDR1 exit and the load continues.
REQ-021 DATA: bytes are assembled little-endian (first byte to bits [7:0]); the 4th accepted byte -> WRITE.
REQ-022 WRITE (exactly one cycle): mem_we = 1 only if word index < DEPTH; mem_addr = index*4; mem_wdata = the assembled word; the index increments.
REQ-023 Words with index >= DEPTH are consumed from the stream but not written (mem_we = 0).
REQ-024 WRITE exits to DONE if the incremented index equals count, otherwise to DATA.
REQ-025 Latency: mem_we asserts in the cycle immediately after the 4th byte handshake; sustained throughput is 4 bytes per 5 cycles.
REQ-026 cpu_hold = 1 in HDR0, HDR1, DATA and WRITE; 0 in IDLE and DONE.
REQ-027 done = 1 in DONE only; mem_we is never asserted outside WRITE.
REQ-028 in_valid = 0 stalls any state without loss of partial header or partial-word data.

Reset
REQ-029 SYS_reset = 0 sampled at a rising edge -> IDLE from any state, including mid-load.
REQ-030 Reset values: in_ready, mem_we, cpu_hold, done and err are 0; mem_addr and mem_wdata are 0; all counters are 0.
REQ-031 A partially assembled word at reset is discarded and never written.

Structure
REQ-032 The shared package holds: the state enumeration, the IMEM_DEPTH constant (1000), and the 16-bit header count width.
REQ-033 One sub-module is natural: byte_packer (4-byte little-endian shift/assemble with a byte count and word_ready output); the FSM stays in imem_loader.

Verification
REQ-034 Reset, then start, then bytes 02 00 | 13 00 00 00 | 93 00 10 00 -> writes (addr 0x0, 0x00000013), then (0x4, 0x00100093); then done = 1, cpu_hold = 0, err = 0.
REQ-035 Header 00 00 -> DONE directly after HDR1 with no mem_we; done = 1.
REQ-036 in_valid toggled 1/0 every cycle during the 2-word load above -> identical writes and data; no byte lost or duplicated.
REQ-037 DEPTH overridden to 2, header 03 00 plus 12 data bytes -> err = 1 after HDR1; writes only at 0x0 and 0x4; all 12 bytes consumed; then DONE.
REQ-038 SYS_reset = 0 after 2 data bytes of word 1 -> IDLE, all outputs 0; a fresh start and a full load then write correctly from address 0.
REQ-039 start pulsed during DATA -> ignored; start pulsed in DONE -> HDR0 with done and err cleared the next cycle.
